dsc_mul_n: RTL and testbench

DSC_MUL_N -- requirements
Module: dsc_mul_n

---
 rtl/dsc_mul_n.sv | 112 +++++++++++
 tb/tb_dsc_mul_n.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_n.sv
// ============================================================================
// Module   : dsc_mul_n
// Purpose  : N-operand unsigned multiplier built from clock-divided unary
//            streams; the product is the count of cycles where every lane is on.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsc_mul_n #(
  parameter int N_IN       = 3,
  parameter int WIDTH      = 6,
  parameter int EARLY_TERM = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [N_IN*WIDTH-1:0]   a_bus,
  output logic [N_IN*WIDTH-1:0]   z,
  output logic                    done,
  output logic                    busy
);

  localparam int c_tw = N_IN * WIDTH;
  localparam int c_lw = (N_IN - 1) * WIDTH;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [WIDTH-1:0] c_one_w  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [c_tw-1:0]  c_one_tw = {{(c_tw-1){1'b0}}, 1'b1};

  logic [1:0]      r_state;
  logic [c_tw-1:0] r_op;
  logic [c_tw-1:0] r_cnt;
  logic [c_tw-1:0] r_acc;
  logic [c_tw-1:0] r_z;

  logic [N_IN-1:0] w_lt;
  logic [N_IN-1:0] w_in_zero;
  logic            w_sn;
  logic            w_last;
  logic            w_zero_op;
  logic [c_tw-1:0] w_acc_nxt;

  // Each lane compares its own slice of the shared counter, so lane k+1 only
  // advances when lane k wraps.
  generate
    for (genvar k = 0; k < N_IN; k++) begin : g_lane
      assign w_lt[k]      = r_cnt[k*WIDTH +: WIDTH] < r_op[k*WIDTH +: WIDTH];
      assign w_in_zero[k] = (a_bus[k*WIDTH +: WIDTH] == {WIDTH{1'b0}});
    end
  endgenerate

  assign w_sn      = &w_lt;
  assign w_zero_op = (EARLY_TERM != 0) && (|w_in_zero);
  assign w_acc_nxt = r_acc + {{(c_tw-1){1'b0}}, w_sn};

  // Early termination stops once the top lane has covered op[top] periods;
  // last count is op[top]*2^lw - 1, detected without a wider counter.
  generate
    if (EARLY_TERM != 0) begin : g_last_early
      assign w_last = (&r_cnt[c_lw-1:0]) &&
                      (r_cnt[c_tw-1 -: WIDTH] == (r_op[c_tw-1 -: WIDTH] - c_one_w));
    end else begin : g_last_full
      assign w_last = &r_cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
      r_op    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_z     <= '0;
    end else if (en) begin
      case (r_state)
        c_idle, c_done: begin
          if (start) begin
            r_op  <= a_bus;
            r_cnt <= '0;
            r_acc <= '0;
            if (w_zero_op) begin
              r_state <= c_done;
              r_z     <= '0;
            end else begin
              r_state <= c_run;
            end
          end
        end
        c_run: begin
          r_cnt <= r_cnt + c_one_tw;
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_z     <= w_acc_nxt;
            r_state <= c_done;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign z    = r_z;
  assign done = (r_state == c_done);
  assign busy = (r_state == c_run);

endmodule

`default_nettype wire

// File: tb/tb_dsc_mul_n.sv
// ============================================================================
// Module   : tb_dsc_mul_n
// Purpose  : Directed bench for dsc_mul_n with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsc_mul_n;

  logic        clk = 1'b0;
  logic        rst_i   [2];
  logic        en_i    [2];
  logic        start_i [2];
  logic [17:0] a_i     [2];

  logic [17:0] z0;
  logic [11:0] z1;
  logic        done0, busy0, done1, busy1;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: early termination, 6-bit operands
  dsc_mul_n #(.N_IN(3), .WIDTH(6), .EARLY_TERM(1)) u_dut0 (
    .clk   (clk),
    .rst   (rst_i[0]),
    .en    (en_i[0]),
    .start (start_i[0]),
    .a_bus (a_i[0]),
    .z     (z0),
    .done  (done0),
    .busy  (busy0)
  );

  // Instance 1: full stream, 4-bit operands (2^12 edges per run)
  dsc_mul_n #(.N_IN(3), .WIDTH(4), .EARLY_TERM(0)) u_dut1 (
    .clk   (clk),
    .rst   (rst_i[1]),
    .en    (en_i[1]),
    .start (start_i[1]),
    .a_bus (a_i[1][11:0]),
    .z     (z1),
    .done  (done1),
    .busy  (busy1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0=idle 1=run 2=done, remaining run edges, product.
  int     m_st  [2] = '{0, 0};
  longint m_rem [2] = '{0, 0};
  longint m_z   [2] = '{0, 0};
  longint m_p   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int     w;
      longint op [3];
      longint len;
      bit     any_zero;
      w = (i == 0) ? 6 : 4;
      any_zero = 1'b0;
      for (int k = 0; k < 3; k++) begin
        op[k] = (longint'(a_i[i]) >> (k * w)) & ((longint'(1) << w) - 1);
        if (op[k] == 0) any_zero = 1'b1;
      end
      if (rst_i[i]) begin
        m_st[i] = 0; m_z[i] = 0; m_rem[i] = 0;
      end else if (en_i[i]) begin
        if (m_st[i] != 1 && start_i[i]) begin
          m_p[i] = op[0] * op[1] * op[2];
          if (i == 0) len = any_zero ? 0 : (op[2] << (2 * w));
          else        len = longint'(1) << (3 * w);
          if (len == 0) begin
            m_st[i] = 2; m_z[i] = 0;
          end else begin
            m_st[i] = 1; m_rem[i] = len;
          end
        end else if (m_st[i] == 1) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_st[i] = 2; m_z[i] = m_p[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      chk("done0", longint'(done0), longint'(m_st[0] == 2));
      chk("busy0", longint'(busy0), longint'(m_st[0] == 1));
      chk("z0",    longint'(z0),    m_z[0] & 64'h3FFFF);
      chk("done1", longint'(done1), longint'(m_st[1] == 2));
      chk("busy1", longint'(busy1), longint'(m_st[1] == 1));
      chk("z1",    longint'(z1),    m_z[1] & 64'hFFF);
    end
  end

  task automatic start_op(input int i, input int o0, input int o1, input int o2);
    int w;
    w = (i == 0) ? 6 : 4;
    @(negedge clk);
    a_i[i]     = 18'((o2 << (2 * w)) | (o1 << w) | o0);
    start_i[i] = 1'b1;
    @(negedge clk);
    start_i[i] = 1'b0;
  endtask

  // Counts enabled-or-not edges after the accepting edge until done is seen.
  task automatic wait_done(input int i, input int maxc, inout int lat);
    while (((i == 0) ? done0 : done1) == 1'b0 && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit saw_busy;
    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1'b1; en_i[i] = 1'b1; start_i[i] = 1'b0; a_i[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    check_on = 1'b1;

    repeat (5) @(negedge clk);
    chk("rst_z0", longint'(z0), 0);
    chk("rst_done0", longint'(done0), 0);
    chk("rst_busy0", longint'(busy0), 0);
    chk("rst_z1", longint'(z1), 0);

    start_op(0, 63, 63, 2);
    lat = 0; wait_done(0, 9000, lat);
    chk("lat_63_63_2", lat, 8192);
    chk("z_63_63_2", longint'(z0), 7938);

    start_op(0, 9, 0, 4);
    lat = 0; wait_done(0, 10, lat);
    chk("lat_zero_op", lat, 0);
    chk("z_zero_op", longint'(z0), 0);
    chk("busy_zero_op", longint'(busy0), 0);

    start_op(0, 1, 1, 1);
    lat = 0; wait_done(0, 5000, lat);
    chk("lat_1_1_1", lat, 4096);
    chk("z_1_1_1", longint'(z0), 1);

    start_op(0, 10, 20, 3);
    lat = 0;
    repeat (50) @(negedge clk);
    lat += 50;
    chk("z_hold_in_run", longint'(z0), 1);
    en_i[0] = 1'b0;
    repeat (100) @(negedge clk);
    en_i[0] = 1'b1;
    lat += 100;
    wait_done(0, 13000, lat);
    chk("lat_en_gap", lat, 12388);
    chk("z_en_gap", longint'(z0), 600);

    start_op(0, 5, 6, 1);
    lat = 0;
    repeat (200) @(negedge clk);
    lat += 200;
    a_i[0] = 18'((2 << 12) | (2 << 6) | 2);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    lat++;
    wait_done(0, 5000, lat);
    chk("lat_restart_ignored", lat, 4096);
    chk("z_restart_ignored", longint'(z0), 30);

    start_op(0, 3, 3, 3);
    repeat (100) @(negedge clk);
    rst_i[0] = 1'b1;
    @(negedge clk);
    rst_i[0] = 1'b0;
    saw_busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0 || busy0) saw_busy = 1'b1;
    end
    chk("abort_quiet", longint'(saw_busy), 0);
    chk("abort_z", longint'(z0), 0);
    start_op(0, 2, 3, 1);
    lat = 0; wait_done(0, 5000, lat);
    chk("lat_after_abort", lat, 4096);
    chk("z_after_abort", longint'(z0), 6);

    start_op(1, 3, 5, 7);
    lat = 0; wait_done(1, 5000, lat);
    chk("full_lat_3_5_7", lat, 4096);
    chk("full_z_3_5_7", longint'(z1), 105);

    start_op(1, 15, 15, 15);
    lat = 0; wait_done(1, 5000, lat);
    chk("full_lat_max", lat, 4096);
    chk("full_z_max", longint'(z1), 3375);

    start_op(1, 0, 5, 7);
    lat = 0; wait_done(1, 5000, lat);
    chk("full_lat_zero", lat, 4096);
    chk("full_z_zero", longint'(z1), 0);

    repeat (5) @(negedge clk);
    chk("done_persists", longint'(done1), 1);
    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
